// File: rtl/branch_predictor.sv
// BTB with 2-bit saturating direction counters; predictions ride an I->R->C
// pipeline so the C stage can report whether its prediction matched the resolution.
`ifndef XLEN
`define XLEN 32
`endif

module branch_predictor #(
    parameter int unsigned ENTRIES = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [`XLEN-1:0]  PC_I,
    input  logic              Stall,
    input  logic              FlushIR,
    input  logic              FlushRC,
    input  logic              Resolve_C,
    input  logic [`XLEN-1:0]  PC_C,
    input  logic              Taken_C,
    input  logic [`XLEN-1:0]  Target_C,
    output logic              Predict,
    output logic [`XLEN-1:0]  Prediction,
    output logic              PredictionCorrect_C
);

    localparam int unsigned IDXW = $clog2(ENTRIES);
    localparam int unsigned TAGW = `XLEN - IDXW - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAGW-1:0]    tag_q    [ENTRIES];
    logic [`XLEN-1:0]   target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic               ir_valid_q, ir_taken_q;
    logic [`XLEN-1:0]   ir_target_q;
    logic               rc_valid_q, rc_taken_q;
    logic [`XLEN-1:0]   rc_target_q;

    logic [IDXW-1:0]    lk_idx, up_idx;
    logic [TAGW-1:0]    lk_tag, up_tag;
    logic               lk_hit, up_hit, up_en;

    // Instruction alignment bits never participate in indexing or tagging.
    logic               unused_pc_bits;
    assign unused_pc_bits = ^{PC_I[1:0], PC_C[1:0]};

    assign lk_idx = PC_I[IDXW+1:2];
    assign lk_tag = PC_I[`XLEN-1:IDXW+2];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    assign Predict    = lk_hit && ctr_q[lk_idx][1];
    assign Prediction = Predict ? {target_q[lk_idx][`XLEN-1:1], 1'b0} : '0;

    assign PredictionCorrect_C = Resolve_C && rc_valid_q && (rc_taken_q == Taken_C) &&
                                 (!Taken_C || rc_target_q == {Target_C[`XLEN-1:1], 1'b0});

    assign up_en  = Resolve_C && rc_valid_q;
    assign up_idx = PC_C[IDXW+1:2];
    assign up_tag = PC_C[`XLEN-1:IDXW+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_valid_q  <= 1'b0;
            ir_taken_q  <= 1'b0;
            ir_target_q <= '0;
            rc_valid_q  <= 1'b0;
            rc_taken_q  <= 1'b0;
            rc_target_q <= '0;
        end else begin
            if (!Stall) begin
                ir_valid_q  <= 1'b1;
                ir_taken_q  <= Predict;
                ir_target_q <= Prediction;
                rc_valid_q  <= ir_valid_q;
                rc_taken_q  <= ir_taken_q;
                rc_target_q <= ir_target_q;
            end
            // Flushes override both capture and stall hold.
            if (FlushIR) ir_valid_q <= 1'b0;
            if (FlushRC) rc_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (up_en) begin
            if (up_hit) begin
                if (Taken_C) begin
                    if (ctr_q[up_idx] != 2'b11) ctr_q[up_idx] <= ctr_q[up_idx] + 2'd1;
                    target_q[up_idx] <= Target_C;
                end else if (ctr_q[up_idx] != 2'b00) begin
                    ctr_q[up_idx] <= ctr_q[up_idx] - 2'd1;
                end
            end else if (Taken_C) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= Target_C;
                ctr_q[up_idx]    <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboarded random + directed bench for branch_predictor against an
// arithmetic reference model of the predictor table and prediction pipeline.
`ifndef XLEN
`define XLEN 32
`endif

module tb_branch_predictor;

    localparam int ENTRIES = 16;
    localparam int IDXW    = 4;
    localparam int XL      = `XLEN;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [XL-1:0] PC_I = 32'h100;
    logic          Stall = 1'b0, FlushIR = 1'b0, FlushRC = 1'b0;
    logic          Resolve_C = 1'b0, Taken_C = 1'b0;
    logic [XL-1:0] PC_C = '0, Target_C = '0;
    logic          Predict, PredictionCorrect_C;
    logic [XL-1:0] Prediction;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .PC_I                (PC_I),
        .Stall               (Stall),
        .FlushIR             (FlushIR),
        .FlushRC             (FlushRC),
        .Resolve_C           (Resolve_C),
        .PC_C                (PC_C),
        .Taken_C             (Taken_C),
        .Target_C            (Target_C),
        .Predict             (Predict),
        .Prediction          (Prediction),
        .PredictionCorrect_C (PredictionCorrect_C)
    );

    typedef struct packed {
        logic          p;
        logic [XL-1:0] t;
        logic          c;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: plain arrays and integer counters.
    bit            m_valid [ENTRIES];
    logic [XL-1:0] m_tag   [ENTRIES];
    logic [XL-1:0] m_tgt   [ENTRIES];
    int            m_ctr   [ENTRIES];
    bit            ir_v, ir_p, rc_v, rc_p;
    logic [XL-1:0] ir_t, rc_t;

    function automatic void check(input string name, input logic [XL-1:0] act,
                                  input logic [XL-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 1;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
        end
        ir_v = 0; ir_p = 0; ir_t = '0;
        rc_v = 0; rc_p = 0; rc_t = '0;
    endfunction

    function automatic int idx_of(input logic [XL-1:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic logic [XL-1:0] tag_of(input logic [XL-1:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic void m_lookup(input logic [XL-1:0] pc, output bit p,
                                     output logic [XL-1:0] t);
        int i = idx_of(pc);
        p = m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
        t = p ? m_tgt[i] - (m_tgt[i] % 2) : '0;
    endfunction

    function automatic bit m_correct();
        return Resolve_C && rc_v && (rc_p == Taken_C) &&
               (!Taken_C || rc_t == Target_C - (Target_C % 2));
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    function automatic void m_step();
        bit            lp;
        logic [XL-1:0] lt;
        int            i;
        if (!reset_n) return;
        m_lookup(PC_I, lp, lt);
        if (Resolve_C && rc_v) begin
            i = idx_of(PC_C);
            if (m_valid[i] && m_tag[i] == tag_of(PC_C)) begin
                if (Taken_C) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_tgt[i] = Target_C;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (Taken_C) begin
                m_valid[i] = 1;
                m_tag[i]   = tag_of(PC_C);
                m_tgt[i]   = Target_C;
                m_ctr[i]   = 2;
            end
        end
        if (!Stall) begin
            rc_v = ir_v; rc_p = ir_p; rc_t = ir_t;
            ir_v = 1;    ir_p = lp;   ir_t = lt;
        end
        if (FlushIR) ir_v = 0;
        if (FlushRC) rc_v = 0;
    endfunction

    function automatic void push_expect();
        bit            p;
        logic [XL-1:0] t;
        m_lookup(PC_I, p, t);
        sb.push_back('{p: p, t: t, c: m_correct()});
    endfunction

    task automatic cyc(input logic [XL-1:0] pc, input bit res = 0,
                       input logic [XL-1:0] pcc = '0, input bit tk = 0,
                       input logic [XL-1:0] tgt = '0, input bit stall = 0,
                       input bit fir = 0, input bit frc = 0);
        @(posedge clk);
        #1;
        m_step();
        reset_n   = 1'b1;
        PC_I      = pc;
        Resolve_C = res;
        PC_C      = pcc;
        Taken_C   = tk;
        Target_C  = tgt;
        Stall     = stall;
        FlushIR   = fir;
        FlushRC   = frc;
        push_expect();
    endtask

    task automatic rst_cyc();
        @(posedge clk);
        #1;
        m_step();
        reset_n = 1'b0;
        m_reset();
        sb.push_back('{p: 1'b0, t: '0, c: 1'b0});
    endtask

    function automatic logic [XL-1:0] rand_pc();
        return 32'h1000 + ($urandom_range(0, 3) << 6) + ($urandom_range(0, 15) << 2);
    endfunction

    function automatic logic [XL-1:0] rand_tgt();
        logic [XL-1:0] opts [4];
        opts[0] = 32'h200; opts[1] = 32'h204; opts[2] = 32'h300; opts[3] = 32'h301;
        return opts[$urandom_range(0, 3)];
    endfunction

    // Monitor: one scoreboard entry per cycle, compared away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_predict",    XL'(Predict),             XL'(e.p));
                check("sb_prediction", Prediction,               e.t);
                check("sb_correct",    XL'(PredictionCorrect_C), XL'(e.c));
            end
        end
    end

    initial begin
        m_reset();
        #2;
        check("reset_predict",    XL'(Predict),             '0);
        check("reset_prediction", Prediction,               '0);
        check("reset_correct",    XL'(PredictionCorrect_C), '0);
        rst_cyc();
        repeat (3) cyc(32'h100);

        // Allocate, then weaken to not-taken.
        cyc(32'h100, 1, 32'h100, 1, 32'h200);
        cyc(32'h100);
        @(negedge clk);
        check("alloc_predict",    XL'(Predict), 1);
        check("alloc_prediction", Prediction,   32'h200);
        cyc(32'h100, 1, 32'h100, 0);
        cyc(32'h100, 1, 32'h100, 0);
        cyc(32'h100);
        @(negedge clk);
        check("weakened_predict", XL'(Predict), 0);

        // Saturation at strongly taken.
        repeat (4) cyc(32'h100, 1, 32'h100, 1, 32'h200);
        cyc(32'h100, 1, 32'h100, 0);
        cyc(32'h100);
        @(negedge clk);
        check("sat_predict",    XL'(Predict), 1);
        check("sat_prediction", Prediction,   32'h200);

        // Same-index alias replaces the entry.
        cyc(32'h100, 1, 32'h140, 1, 32'h300);
        cyc(32'h100);
        @(negedge clk);
        check("alias_old_predict", XL'(Predict), 0);
        cyc(32'h140);
        @(negedge clk);
        check("alias_new_predict",    XL'(Predict), 1);
        check("alias_new_prediction", Prediction,   32'h300);

        // Prediction travels to C and is compared against resolution.
        cyc(32'h0, 1, 32'h100, 1, 32'h200);
        cyc(32'h100);
        cyc(32'h0);
        cyc(32'h0, 1, 32'h100, 1, 32'h200, 1);
        @(negedge clk);
        check("correct_match", XL'(PredictionCorrect_C), 1);
        cyc(32'h0, 1, 32'h100, 1, 32'h204, 1);
        @(negedge clk);
        check("correct_wrong_target", XL'(PredictionCorrect_C), 0);

        // FlushRC squashes; a would-be allocation at index 0 must not happen.
        cyc(32'h100);
        cyc(32'h0, 0, '0, 0, '0, 0, 0, 1);
        cyc(32'h0, 1, 32'h180, 1, 32'h400, 1);
        @(negedge clk);
        check("flushrc_correct", XL'(PredictionCorrect_C), 0);
        cyc(32'h100);
        @(negedge clk);
        check("flushrc_no_update_predict",    XL'(Predict), 1);
        check("flushrc_no_update_prediction", Prediction,   32'h204);

        // Stall holds R->C while PC_I moves.
        cyc(32'h100);
        cyc(32'h0);
        for (int k = 0; k < 3; k++) begin
            cyc(32'h300 + 32'(k * 260), 1, 32'h100, 1, 32'h204, 1);
            @(negedge clk);
            check("stall_hold_correct", XL'(PredictionCorrect_C), 1);
        end

        // FlushIR under Stall clears I->R; that bubble reaches C.
        cyc(32'h100);
        cyc(32'h0, 0, '0, 0, '0, 1, 1, 0);
        cyc(32'h0);
        cyc(32'h0, 1, 32'h100, 1, 32'h204, 1);
        @(negedge clk);
        check("flushir_stall_correct", XL'(PredictionCorrect_C), 0);

        // Reset mid-resolution discards it and clears the table.
        cyc(32'h100, 1, 32'h100, 0, '0, 1);
        rst_cyc();
        rst_cyc();
        cyc(32'h100);
        @(negedge clk);
        check("midreset_predict", XL'(Predict), 0);
        repeat (2) cyc(32'h100);

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) < 2) begin
                rst_cyc();
            end else begin
                cyc(rand_pc(), ($urandom_range(0, 1) == 1), rand_pc(),
                    ($urandom_range(0, 2) != 0), rand_tgt(),
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 9) == 0));
            end
        end

        cyc(32'h0);
        @(negedge clk);
        @(negedge clk);
        check("sb_drained", XL'(sb.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
